fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register; feeds decode with instr/pc.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, skid buffer, flush/redirect and HLT detection.
// Optional stall-cycle counter on perf_cnt when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] pc_branch,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [15:0] skid_instr;
  logic [15:0] skid_pc;
  logic        skid_hlt;
  logic        fetched_hlt;

  assign pc_plus2    = pc + 16'd2;
  assign fetched_hlt = (imem_rdata[15:12] == HLT_OPCODE);
  assign imem_req    = (state == S_FETCH) && !rst;
  assign imem_addr   = pc;

  // PC, state, skid buffer and IF/ID register; priority rst > flush > stall > normal
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      instr_out  <= NOP_INSTR;
      pc_out     <= 16'h0000;
      valid_out  <= 1'b0;
      halted     <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 16'h0000;
      skid_hlt   <= 1'b0;
    end else if (flush) begin
      pc         <= pc_branch;
      instr_out  <= NOP_INSTR;
      valid_out  <= 1'b0;
      halted     <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 16'h0000;
      skid_hlt   <= 1'b0;
      // A word still in flight must be swallowed before fetching from the new target
      if (((state == S_FETCH) || (state == S_DISCARD)) && !imem_valid) begin
        state <= S_DISCARD;
      end else begin
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            if (stall) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc_plus2;
              skid_hlt   <= fetched_hlt;
              state      <= S_HOLD;
            end else begin
              instr_out <= imem_rdata;
              pc_out    <= pc_plus2;
              valid_out <= 1'b1;
              if (fetched_hlt) begin
                state  <= S_HALT;
                halted <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
            if (!fetched_hlt) begin
              pc <= pc_plus2;
            end
          end else if (!stall) begin
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_out <= skid_instr;
            pc_out    <= skid_pc;
            valid_out <= 1'b1;
            if (skid_hlt) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_DISCARD: begin
          if (imem_valid) begin
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (!stall) begin
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
          end
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating count of cycles in which fetch makes no forward progress
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= 16'h0000;
    end else if ((stall || ((state == S_FETCH) && !imem_valid) || (state == S_DISCARD))
                 && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end
`endif

endmodule
